// File: rtl/oc8051_multiply_seq_if.sv
// Handshake/result bundle between the ALU (master) and the iterative
// multiplier (slave). The sgn signal exists only when OC8051_MUL_SIGNED_EN
// is defined.
interface oc8051_multiply_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
`ifdef OC8051_MUL_SIGNED_EN
  logic             sgn;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] des_hi;
  logic [WIDTH-1:0] des_lo;
  logic             des_ov;

  modport master (
    output start, src1, src2,
`ifdef OC8051_MUL_SIGNED_EN
    output sgn,
`endif
    input  busy, done, des_hi, des_lo, des_ov
  );

  modport slave (
    input  start, src1, src2,
`ifdef OC8051_MUL_SIGNED_EN
    input  sgn,
`endif
    output busy, done, des_hi, des_lo, des_ov
  );
endinterface

// File: rtl/oc8051_multiply_seq.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier, DIGIT multiplier bits per
// clock, MSB digit first, with start/busy/done handshake. Results are held
// until the next completion.
// Optional feature macro: OC8051_MUL_SIGNED_EN (adds signed mode via sgn).
module oc8051_multiply_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  oc8051_multiply_seq_if.slave bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   src1_q, src1_d;
  logic [WIDTH-1:0]   src2_q, src2_d;
  logic               sgn_q, sgn_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   des_hi_q, des_hi_d;
  logic [WIDTH-1:0]   des_lo_q, des_lo_d;
  logic               des_ov_q, des_ov_d;

  logic               sgn_in;
  logic [WIDTH-1:0]   src1_mag, src2_mag;
  logic [DIGIT-1:0]   digit;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;

  // State and datapath registers, asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      des_hi_q <= '0;
      des_lo_q <= '0;
      des_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      des_hi_q <= des_hi_d;
      des_lo_q <= des_lo_d;
      des_ov_q <= des_ov_d;
    end
  end

  // Next-state: leave IDLE on start, return after the last digit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (cnt_q == CNT_LAST) state_d = IDLE;
    endcase
  end

  // Operand conditioning: signed operands are reduced to magnitudes so the
  // iteration core stays unsigned; the sign is reapplied on the final edge.
  always_comb begin
    sgn_in = 1'b0;
`ifdef OC8051_MUL_SIGNED_EN
    sgn_in = bus.sgn;
`endif
    src1_mag = (sgn_in && bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
    src2_mag = (sgn_in && bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;
  end

  // Datapath: digit-serial shift-and-add plus result capture
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    des_hi_d = des_hi_q;
    des_lo_d = des_lo_q;
    des_ov_d = des_ov_q;

    digit    = DIGIT'(src2_q >> (WIDTH - DIGIT * (int'(cnt_q) + 1)));
    pp       = (2*WIDTH)'(src1_q) * (2*WIDTH)'(digit);
    acc_step = (acc_q << DIGIT) + pp;
    prod     = neg_q ? -acc_step : acc_step;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          src1_d = src1_mag;
          src2_d = src2_mag;
          sgn_d  = sgn_in;
          neg_d  = sgn_in & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
          cnt_d  = '0;
          acc_d  = '0;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          done_d   = 1'b1;
          des_hi_d = prod[2*WIDTH-1:WIDTH];
          des_lo_d = prod[WIDTH-1:0];
          if (sgn_q)
            des_ov_d = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
          else
            des_ov_d = |prod[2*WIDTH-1:WIDTH];
        end
      end
    endcase
  end

  // Outputs: busy decoded from state, results straight from registers
  always_comb begin
    bus.busy   = (state_q == RUN);
    bus.done   = done_q;
    bus.des_hi = des_hi_q;
    bus.des_lo = des_lo_q;
    bus.des_ov = des_ov_q;
  end
endmodule

// File: tb/tb_oc8051_multiply_seq.sv
// Directed bench for oc8051_multiply_seq: 8x8/DIGIT=2 main instance plus
// 16x16/DIGIT=4 and 8x8/DIGIT=1 instances for the parameter corners.
module tb_oc8051_multiply_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc;
  int   seen_done;

  always #5 clk = ~clk;

  oc8051_multiply_seq_if #(.WIDTH(8))  mif ();
  oc8051_multiply_seq_if #(.WIDTH(16)) m16 ();
  oc8051_multiply_seq_if #(.WIDTH(8))  m1 ();

  oc8051_multiply_seq #(.WIDTH(8),  .DIGIT(2)) u_dut   (.clk(clk), .rst(rst), .bus(mif));
  oc8051_multiply_seq #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst(rst), .bus(m16));
  oc8051_multiply_seq #(.WIDTH(8),  .DIGIT(1)) u_dut1  (.clk(clk), .rst(rst), .bus(m1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one accepting edge
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s);
    mif.start = 1'b1;
    mif.src1  = a;
    mif.src2  = b;
`ifdef OC8051_MUL_SIGNED_EN
    mif.sgn   = s;
`else
    if (s) check("sgn_not_built", 1'b1, 1'b0);
`endif
    tick();
    mif.start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded)
  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (c < budget) begin
      tick();
      c++;
      if (mif.done) return;
    end
    c = budget + 1;
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [15:0] exp_p, input logic exp_ov);
    int c;
    launch(a, b, s);
    check({tag, "_busy"}, mif.busy, 1'b1);
    wait_done(20, c);
    check({tag, "_lat"}, c, 4);
    check({tag, "_hi"}, mif.des_hi, exp_p[15:8]);
    check({tag, "_lo"}, mif.des_lo, exp_p[7:0]);
    check({tag, "_ov"}, mif.des_ov, exp_ov);
    check({tag, "_busy_end"}, mif.busy, 1'b0);
    tick();
    check({tag, "_done_pulse"}, mif.done, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    mif.start = 1'b0; mif.src1 = '0; mif.src2 = '0;
    m16.start = 1'b0; m16.src1 = '0; m16.src2 = '0;
    m1.start  = 1'b0; m1.src1  = '0; m1.src2  = '0;
`ifdef OC8051_MUL_SIGNED_EN
    mif.sgn = 1'b0; m16.sgn = 1'b0; m1.sgn = 1'b0;
`endif
    tick();
    tick();
    check("rst_busy", mif.busy, 1'b0);
    check("rst_done", mif.done, 1'b0);
    check("rst_hi", mif.des_hi, 8'h00);
    check("rst_lo", mif.des_lo, 8'h00);
    check("rst_ov", mif.des_ov, 1'b0);
    rst = 1'b0;
    tick();

    run("ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);

    // Second start during busy must be ignored; outputs hold old result
    launch(8'h12, 8'h0A, 1'b0);
    tick();
    mif.start = 1'b1; mif.src1 = 8'h01; mif.src2 = 8'h01;
    tick();
    mif.start = 1'b0; mif.src1 = 8'h00; mif.src2 = 8'h00;
    check("ign_busy", mif.busy, 1'b1);
    check("ign_hold_hi", mif.des_hi, 8'hFE);
    check("ign_hold_lo", mif.des_lo, 8'h01);
    wait_done(20, cyc);
    check("ign_lat", cyc, 2);
    check("ign_hi", mif.des_hi, 8'h00);
    check("ign_lo", mif.des_lo, 8'hB4);
    check("ign_ov", mif.des_ov, 1'b0);
    tick();

    run("zero", 8'h00, 8'h55, 1'b0, 16'h0000, 1'b0);

    // Back-to-back: start held high across done
    mif.start = 1'b1; mif.src1 = 8'h10; mif.src2 = 8'h10;
    tick();
    mif.src1 = 8'h03; mif.src2 = 8'h05;
    wait_done(20, cyc);
    check("b2b1_lat", cyc, 4);
    check("b2b1_hi", mif.des_hi, 8'h01);
    check("b2b1_lo", mif.des_lo, 8'h00);
    check("b2b1_ov", mif.des_ov, 1'b1);
    tick();
    mif.start = 1'b0;
    check("b2b2_busy", mif.busy, 1'b1);
    wait_done(20, cyc);
    check("b2b2_spacing", cyc + 1, 5);
    check("b2b2_hi", mif.des_hi, 8'h00);
    check("b2b2_lo", mif.des_lo, 8'h0F);
    check("b2b2_ov", mif.des_ov, 1'b0);
    tick();

    // Reset abort mid-operation
    launch(8'hFF, 8'h02, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", mif.busy, 1'b0);
    check("abort_done", mif.done, 1'b0);
    check("abort_hi", mif.des_hi, 8'h00);
    check("abort_lo", mif.des_lo, 8'h00);
    check("abort_ov", mif.des_ov, 1'b0);
    tick();
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mif.done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    run("after_abort", 8'h07, 8'h06, 1'b0, 16'h002A, 1'b0);

`ifdef OC8051_MUL_SIGNED_EN
    run("s_neg3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0);
    run("s_min_min", 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
    run("u_fdx5", 8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b1);
`endif

    // WIDTH=16, DIGIT=4
    m16.start = 1'b1; m16.src1 = 16'hFFFF; m16.src2 = 16'hFFFF;
    tick();
    m16.start = 1'b0;
    cyc = 0;
    while (!m16.done && cyc < 20) begin
      tick();
      cyc++;
    end
    check("w16_lat", cyc, 4);
    check("w16_hi", m16.des_hi, 16'hFFFE);
    check("w16_lo", m16.des_lo, 16'h0001);
    check("w16_ov", m16.des_ov, 1'b1);

    // WIDTH=8, DIGIT=1: 165*60 = 9900
    m1.start = 1'b1; m1.src1 = 8'hA5; m1.src2 = 8'h3C;
    tick();
    m1.start = 1'b0;
    cyc = 0;
    while (!m1.done && cyc < 20) begin
      tick();
      cyc++;
    end
    check("d1_lat", cyc, 8);
    check("d1_hi", m1.des_hi, 8'h26);
    check("d1_lo", m1.des_lo, 8'hAC);
    check("d1_ov", m1.des_ov, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
